// File: rtl/datapath_if.sv
// Purpose : instruction/operand bundle between the control unit and the datapath.
// Latency : wires only; douta/doutb are combinational register reads.
// Backpr. : none; the datapath accepts one instruction per clock.
//
// Signals (control unit -> datapath): enable, a, b, w, din, load_store,
//   op_ula, operation_type, ula_entry.
// Signals (datapath -> control unit): douta, doutb.
interface datapath_if #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
);
    logic              enable;
    logic [REG_AW-1:0] a;
    logic [REG_AW-1:0] b;
    logic [REG_AW-1:0] w;
    logic [DATA_W-1:0] din;
    logic              load_store;
    logic              op_ula;
    logic              operation_type;
    logic              ula_entry;
    logic [DATA_W-1:0] douta;
    logic [DATA_W-1:0] doutb;

    // Control unit side.
    modport master (
        output enable, a, b, w, din, load_store, op_ula, operation_type, ula_entry,
        input  douta, doutb
    );

    // Datapath side.
    modport slave (
        input  enable, a, b, w, din, load_store, op_ula, operation_type, ula_entry,
        output douta, doutb
    );
endinterface

// File: rtl/datapath.sv
// Purpose : single-cycle 64-bit load/store/add/sub datapath (32x64 regfile, add/sub ALU, 64-word RAM).
// Latency : one clock per instruction; results readable on douta/doutb right after the edge.
// Backpr. : none; no stall or handshake, enable=0 simply freezes all state.
//
// Ports:
//   clk   - rising-edge clock for all state.
//   reset - asynchronous active-high; clears registers, loads RAM word i with i.
//   bus   - datapath_if.slave: instruction fields in, douta/doutb register reads out.
module datapath #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int MEM_AW = 6
) (
    input  logic     clk,
    input  logic     reset,
    datapath_if.slave bus
);
    localparam int NREG = 1 << REG_AW;
    localparam int NMEM = 1 << MEM_AW;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_mem  [NMEM];

    logic [DATA_W-1:0] w_douta;
    logic [DATA_W-1:0] w_doutb;
    logic [DATA_W-1:0] w_alu_y;
    logic [DATA_W-1:0] w_result;
    logic [MEM_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_wb;
    logic              w_reg_we;
    logic              w_mem_we;

    // x0 is never written and is cleared by reset, so it always reads zero.
    assign w_douta   = r_regs[bus.a];
    assign w_doutb   = r_regs[bus.b];
    assign bus.douta = w_douta;
    assign bus.doutb = w_doutb;

    // ALU: X is always reg[b]; Y is either the immediate or reg[a].
    assign w_alu_y  = bus.ula_entry ? w_douta : bus.din;
    assign w_result = bus.op_ula ? (w_doutb + w_alu_y) : (w_doutb - w_alu_y);

    // Only the low address bits reach the RAM, so addresses wrap at NMEM words.
    assign w_addr  = w_result[MEM_AW-1:0];
    assign w_rdata = r_mem[w_addr];
    assign w_wb    = bus.operation_type ? w_result : w_rdata;

    assign w_reg_we = bus.enable && bus.load_store && (bus.w != '0);
    assign w_mem_we = bus.enable && !bus.load_store;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_we) begin
            r_regs[bus.w] <= w_wb;
        end
    end

    // RAM reset contents are the identity map, which makes loads after reset predictable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NMEM; i++) begin
                r_mem[i] <= DATA_W'(i);
            end
        end else if (w_mem_we) begin
            r_mem[w_addr] <= w_douta;
        end
    end
endmodule

// File: tb/tb_datapath.sv
// Purpose : self-checking bench for datapath: directed test-plan steps, then random instructions
//           compared against an array-based architectural model.
// Latency : expects each instruction's effect to be visible just after its clock edge.
// Backpr. : none exercised; the datapath has no flow control.
module tb_datapath;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [63:0] mregs [32];
    logic [63:0] mmem  [64];

    datapath_if #(.DATA_W(64), .REG_AW(5)) dp_if ();

    datapath #(.DATA_W(64), .REG_AW(5), .MEM_AW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        for (int i = 0; i < 64; i++) mmem[i] = 64'(i);
    endtask

    // Architectural effect of one instruction, straight from the instruction rules.
    task automatic model_exec(input logic en, input logic ls, input logic opt, input logic ue,
                              input logic op, input logic [4:0] wa, input logic [4:0] aa,
                              input logic [4:0] ba, input logic [63:0] imm);
        logic [63:0] x, y, res;
        int addr;
        x    = mregs[ba];
        y    = ue ? mregs[aa] : imm;
        res  = op ? x + y : x - y;
        addr = int'(res % 64);
        if (en) begin
            if (ls) begin
                if (wa != 0) mregs[wa] = opt ? res : mmem[addr];
            end else begin
                mmem[addr] = mregs[aa];
            end
        end
    endtask

    // Drive one instruction, check the pre-edge read, clock it, update the model.
    task automatic exec(input logic en, input logic ls, input logic opt, input logic ue,
                        input logic op, input logic [4:0] wa, input logic [4:0] aa,
                        input logic [4:0] ba, input logic [63:0] imm);
        dp_if.enable         = en;
        dp_if.load_store     = ls;
        dp_if.operation_type = opt;
        dp_if.ula_entry      = ue;
        dp_if.op_ula         = op;
        dp_if.w              = wa;
        dp_if.a              = aa;
        dp_if.b              = ba;
        dp_if.din            = imm;
        #1;
        chk("pre_edge_douta", dp_if.douta, mregs[aa]);
        @(posedge clk);
        model_exec(en, ls, opt, ue, op, wa, aa, ba, imm);
        #1;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [4:0] rb, input logic [63:0] imm);
        exec(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rd, 5'd0, rb, imm);
    endtask

    task automatic alu(input logic op, input logic [4:0] rd, input logic [4:0] rb, input logic [4:0] ra);
        exec(1'b1, 1'b1, 1'b1, 1'b1, op, rd, ra, rb, 64'd0);
    endtask

    task automatic st(input logic [4:0] ra, input logic [4:0] rb, input logic [63:0] imm);
        exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, ra, rb, imm);
    endtask

    // Point the read ports at two registers and compare against the given expectations.
    task automatic peek(input string tag, input logic [4:0] aa, input logic [4:0] ba,
                        input logic [63:0] ea, input logic [63:0] eb);
        dp_if.enable = 1'b0;
        dp_if.a      = aa;
        dp_if.b      = ba;
        #1;
        chk({tag, "_douta"}, dp_if.douta, ea);
        chk({tag, "_doutb"}, dp_if.doutb, eb);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        reset                = 1'b1;
        dp_if.enable         = 1'b0;
        dp_if.load_store     = 1'b0;
        dp_if.operation_type = 1'b0;
        dp_if.ula_entry      = 1'b0;
        dp_if.op_ula         = 1'b0;
        dp_if.w              = '0;
        dp_if.a              = '0;
        dp_if.b              = '0;
        dp_if.din            = '0;
        repeat (3) @(posedge clk);
        #1;
        peek("reset_held", 5'd1, 5'd31, 64'd0, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            dp_if.a = 5'(i);
            #1;
            chk("reset_reg", dp_if.douta, 64'd0);
        end

        // Loads from identity RAM.
        ld(5'd1, 5'd0, 64'd7);
        ld(5'd2, 5'd0, 64'd9);
        peek("loads", 5'd1, 5'd2, 64'd7, 64'd9);

        // Add then sub (reg[b] - reg[a]).
        alu(1'b1, 5'd3, 5'd1, 5'd2);
        alu(1'b0, 5'd4, 5'd3, 5'd1);
        peek("add_sub", 5'd3, 5'd4, 64'd16, 64'd9);

        // Store then reload.
        st(5'd3, 5'd0, 64'd3);
        st(5'd4, 5'd0, 64'd4);
        ld(5'd31, 5'd0, 64'd3);
        ld(5'd30, 5'd0, 64'd4);
        peek("store_reload", 5'd31, 5'd30, 64'd16, 64'd9);

        // Write inhibit and x0.
        exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd0, 64'd20);
        ld(5'd0, 5'd0, 64'd20);
        peek("inhibit_x0", 5'd5, 5'd0, 64'd0, 64'd0);

        // 0 - 1 wraps; offset 70 wraps to word 6.
        ld(5'd8, 5'd0, 64'd1);
        alu(1'b0, 5'd6, 5'd0, 5'd8);
        ld(5'd9, 5'd0, 64'd70);
        peek("wrap", 5'd6, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd6);

        // Async reset between edges.
        @(negedge clk);
        dp_if.a = 5'd31;
        dp_if.b = 5'd30;
        #1;
        chk("pre_async_douta", dp_if.douta, 64'd16);
        reset = 1'b1;
        #1;
        chk("async_douta", dp_if.douta, 64'd0);
        chk("async_doutb", dp_if.doutb, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        ld(5'd7, 5'd0, 64'd3);
        peek("post_reset_load", 5'd7, 5'd3, 64'd3, 64'd0);

        // Random instructions against the model.
        for (int n = 0; n < 300; n++) begin
            logic [4:0]  ra, rb, rd;
            logic [63:0] imm;
            logic        en;
            int          kind;
            ra   = 5'($urandom_range(0, 31));
            rb   = 5'($urandom_range(0, 31));
            rd   = 5'($urandom_range(0, 31));
            imm  = {$urandom, $urandom};
            en   = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 3);
            case (kind)
                0: exec(en, 1'b1, 1'b0, 1'b0, 1'b1, rd, ra, rb, imm);
                1: exec(en, 1'b1, 1'b1, 1'b1, 1'b1, rd, ra, rb, imm);
                2: exec(en, 1'b1, 1'b1, 1'b1, 1'b0, rd, ra, rb, imm);
                default: exec(en, 1'b0, 1'b0, 1'b0, 1'b1, rd, ra, rb, imm);
            endcase
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            peek("rand", ra, rb, mregs[ra], mregs[rb]);
        end

        // Sweep every register, then read back every RAM word through x1.
        for (int i = 0; i < 32; i++) begin
            peek("sweep_reg", 5'(i), 5'(31 - i), mregs[i], mregs[31 - i]);
        end
        for (int i = 0; i < 64; i++) begin
            ld(5'd1, 5'd0, 64'(i));
            peek("sweep_mem", 5'd1, 5'd0, mmem[i], 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
